// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file FSM encoding, default sizes and clear-counter width.
package cpu_pkg;

  localparam int XLEN_DEFAULT  = 64;
  localparam int NREGS_DEFAULT = 32;

  typedef enum logic {
    RF_STATE_CLEAR = 1'b0,
    RF_STATE_RUN   = 1'b1
  } rf_state_e;

  // One bit wider than the address so the sweep reaches NREGS-1 without wrapping.
  function automatic int rf_cnt_width(input int nregs);
    return $clog2(nregs) + 1;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: source/destination addresses, write data, registered read data, ready.
// master = operand-fetch side, slave = register file.
interface regfile_mp_if #(
  parameter int XLEN  = cpu_pkg::XLEN_DEFAULT,
  parameter int NREGS = cpu_pkg::NREGS_DEFAULT,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic                stall_in;
  logic [NRD*AW-1:0]   rs_in;
  logic [AW-1:0]       rd_in;
  logic                rd_write_in;
  logic [XLEN-1:0]     rd_value_in;
  logic [NRD*XLEN-1:0] rs_value_out;
  logic                ready_out;

  modport master (
    output stall_in, rs_in, rd_in, rd_write_in, rd_value_in,
    input  rs_value_out, ready_out
  );

  modport slave (
    input  stall_in, rs_in, rd_in, rd_write_in, rd_value_in,
    output rs_value_out, ready_out
  );

endinterface

// File: rtl/regfile_rdport.sv
// One read port: array mux, zero-register mask, optional same-cycle bypass (REGFILE_BYPASS_EN).
// Output registered (1 cycle), held while stall is high, forced to 0 under reset and during the clear sweep.
module regfile_rdport
  import cpu_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset_in,
  input  logic            run,
  input  logic            stall,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] regs [NREGS],
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] rd_q
);

  logic [XLEN-1:0] rd_val;

  always_comb begin
    rd_val = regs[addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wr_addr == addr)) begin
      rd_val = wr_data;
    end
`endif
    // Mask last so a dropped write to r0 can never leak through the bypass.
    if ((ZERO_REG != 0) && (addr == '0)) begin
      rd_val = '0;
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  always_ff @(posedge clk) begin
    if (reset_in) begin
      rd_q <= '0;
    end else if (!run) begin
      rd_q <= '0;
    end else if (!stall) begin
      rd_q <= rd_val;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / 1-write register file with a post-reset clear sweep; bypass via REGFILE_BYPASS_EN.
// Reads are registered (1 cycle) and held on stall_in; ready_out rises when the NREGS-cycle sweep ends.
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         reset_in,
  regfile_mp_if.slave rf
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = rf_cnt_width(NREGS);

  rf_state_e       state;
  logic [CW-1:0]   clr_cnt;
  logic            ready_q;
  logic            run;
  logic            wr_en;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] rd_q [NRD];

  assign run   = (state == RF_STATE_RUN);
  assign wr_en = run && rf.rd_write_in && !((ZERO_REG != 0) && (rf.rd_in == '0));

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state   <= RF_STATE_CLEAR;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else if (state == RF_STATE_CLEAR) begin
      clr_cnt <= clr_cnt + CW'(1);
      if (clr_cnt == CW'(NREGS - 1)) begin
        state   <= RF_STATE_RUN;
        ready_q <= 1'b1;
      end
    end
  end

  // Array has no reset of its own; the sweep clears it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!reset_in) begin
      if (state == RF_STATE_CLEAR) begin
        regs[clr_cnt[AW-1:0]] <= '0;
      end else if (wr_en) begin
        regs[rf.rd_in] <= rf.rd_value_in;
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_rdport #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
    ) u_rdport (
      .clk      (clk),
      .reset_in (reset_in),
      .run      (run),
      .stall    (rf.stall_in),
      .addr     (rf.rs_in[p*AW +: AW]),
      .regs     (regs),
      .wr_en    (wr_en),
      .wr_addr  (rf.rd_in),
      .wr_data  (rf.rd_value_in),
      .rd_q     (rd_q[p])
    );
    assign rf.rs_value_out[p*XLEN +: XLEN] = rd_q[p];
  end

  assign rf.ready_out = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboarded bench for regfile_mp: ZERO_REG=1 and ZERO_REG=0 instances share stimulus;
// expected outputs come from an array model of the register file. Honours REGFILE_BYPASS_EN.
module tb_regfile_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;

`ifdef REGFILE_BYPASS_EN
  localparam logic [63:0] HAZ_EXP = 64'h1234;
`else
  localparam logic [63:0] HAZ_EXP = 64'h0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        wr;
  logic [4:0]  rs [2];
  logic [4:0]  rd;
  logic [63:0] wval;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) if_z ();
  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) if_n ();

  assign if_z.stall_in    = stall;
  assign if_z.rs_in       = {rs[1], rs[0]};
  assign if_z.rd_in       = rd;
  assign if_z.rd_write_in = wr;
  assign if_z.rd_value_in = wval;
  assign if_n.stall_in    = stall;
  assign if_n.rs_in       = {rs[1], rs[0]};
  assign if_n.rd_in       = rd;
  assign if_n.rd_write_in = wr;
  assign if_n.rd_value_in = wval;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset_in(rst), .rf(if_z)
  );
  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(0)) dut_n (
    .clk(clk), .reset_in(rst), .rf(if_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural contents, remaining sweep cycles, held outputs.
  logic [63:0] mem_z [NREGS];
  logic [63:0] mem_n [NREGS];
  logic [63:0] out_z [2];
  logic [63:0] out_n [2];
  int          sweep_left = NREGS;

  typedef struct packed {
    logic        rdy;
    logic [63:0] z0;
    logic [63:0] z1;
    logic [63:0] n0;
    logic [63:0] n1;
  } exp_t;

  exp_t sb_q [$];
  exp_t mon_e;

  task automatic model_step();
    exp_t        e;
    logic [63:0] vz, vn;
    if (rst) begin
      sweep_left = NREGS;
      for (int i = 0; i < NREGS; i++) begin
        mem_z[i] = '0;
        mem_n[i] = '0;
      end
      for (int p = 0; p < 2; p++) begin
        out_z[p] = '0;
        out_n[p] = '0;
      end
    end else if (sweep_left > 0) begin
      sweep_left--;
    end else begin
      for (int p = 0; p < 2; p++) begin
        vz = mem_z[rs[p]];
        vn = mem_n[rs[p]];
`ifdef REGFILE_BYPASS_EN
        if (wr && rd == rs[p]) begin
          vz = wval;
          vn = wval;
        end
`endif
        if (rs[p] == 5'd0) vz = '0;
        if (!stall) begin
          out_z[p] = vz;
          out_n[p] = vn;
        end
      end
      if (wr) begin
        if (rd != 5'd0) mem_z[rd] = wval;
        mem_n[rd] = wval;
      end
    end
    e.rdy = (sweep_left == 0);
    e.z0  = out_z[0];
    e.z1  = out_z[1];
    e.n0  = out_n[0];
    e.n1  = out_n[1];
    sb_q.push_back(e);
  endtask

  // Inputs are applied 1 time unit after a rising edge; expectation for the next edge is queued.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("ready_z", {63'b0, if_z.ready_out}, {63'b0, mon_e.rdy});
      chk("ready_n", {63'b0, if_n.ready_out}, {63'b0, mon_e.rdy});
      chk("sb_z_p0", if_z.rs_value_out[63:0],   mon_e.z0);
      chk("sb_z_p1", if_z.rs_value_out[127:64], mon_e.z1);
      chk("sb_n_p0", if_n.rs_value_out[63:0],   mon_e.n0);
      chk("sb_n_p1", if_n.rs_value_out[127:64], mon_e.n1);
    end
  end

  function automatic logic [4:0] rand_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  task automatic rand_reads();
    rs[0] = rand_addr();
    rs[1] = rand_addr();
  endtask

  int n;

  initial begin
    rst = 1'b1; stall = 1'b0; wr = 1'b0; rd = '0; wval = '0;
    rs[0] = '0; rs[1] = '0;

    repeat (3) cyc();
    rst = 1'b0;

    // Sweep interrupted at cycle 10 with a write pulse that must be ignored.
    for (int i = 0; i < 10; i++) begin
      rand_reads();
      wr = (i == 4); rd = 5'd9; wval = 64'h55;
      cyc();
    end
    wr = 1'b0;
    chk("ready_mid_sweep", {63'b0, if_z.ready_out}, 64'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    n = 0;
    while (!if_z.ready_out && n < 40) begin
      rand_reads();
      wr = (n == 3 || n == 20); rd = 5'd9; wval = 64'h55;
      cyc();
      n++;
    end
    wr = 1'b0;
    chk("ready_latency", 64'(n), 64'd32);

    for (int a = 0; a < NREGS; a++) begin
      rs[0] = 5'(a); rs[1] = 5'(NREGS - 1 - a);
      cyc();
      chk("sweep_zero_p0", if_z.rs_value_out[63:0], 64'd0);
      chk("sweep_zero_p1", if_n.rs_value_out[127:64], 64'd0);
    end

    // Write r5, read it back on both ports the following cycle.
    rd = 5'd5; wr = 1'b1; wval = 64'hDEADBEEF_00000001; rs[0] = 5'd1; rs[1] = 5'd2;
    cyc();
    wr = 1'b0; rs[0] = 5'd5; rs[1] = 5'd5;
    cyc();
    chk("r5_p0", if_z.rs_value_out[63:0],   64'hDEADBEEF_00000001);
    chk("r5_p1", if_z.rs_value_out[127:64], 64'hDEADBEEF_00000001);
    chk("r5_n_p1", if_n.rs_value_out[127:64], 64'hDEADBEEF_00000001);

    // r0: hardwired in dut_z, ordinary in dut_n.
    rd = 5'd0; wr = 1'b1; wval = 64'hFFFF;
    cyc();
    wr = 1'b0; rs[0] = 5'd0; rs[1] = 5'd0;
    cyc();
    chk("r0_zero_reg1", if_z.rs_value_out[63:0], 64'd0);
    chk("r0_zero_reg0", if_n.rs_value_out[63:0], 64'hFFFF);

    // Same-cycle write/read of r7.
    rd = 5'd7; wr = 1'b1; wval = 64'h1234; rs[0] = 5'd7; rs[1] = 5'd7;
    cyc();
    wr = 1'b0;
    chk("hazard_p0", if_z.rs_value_out[63:0],   HAZ_EXP);
    chk("hazard_p1", if_n.rs_value_out[127:64], HAZ_EXP);
    cyc();
    chk("hazard_next", if_z.rs_value_out[63:0], 64'h1234);

    // Stall hold: outputs keep 0xA while r3 is rewritten to 0xB.
    rd = 5'd3; wr = 1'b1; wval = 64'hA; rs[0] = 5'd1; rs[1] = 5'd1;
    cyc();
    wr = 1'b0; rs[0] = 5'd3;
    cyc();
    chk("stall_pre", if_z.rs_value_out[63:0], 64'hA);
    stall = 1'b1; wr = 1'b1; wval = 64'hB; rs[0] = 5'd5;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("stall_hold", if_z.rs_value_out[63:0], 64'hA);
    end
    stall = 1'b0; wr = 1'b0; rs[0] = 5'd3;
    cyc();
    chk("stall_release", if_z.rs_value_out[63:0], 64'hB);

    // Randomised traffic, including occasional resets and stalls.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 599) == 0);
      stall = ($urandom_range(0, 4) == 0);
      wr    = ($urandom_range(0, 1) == 1);
      rd    = rand_addr();
      wval  = {$urandom, $urandom};
      rand_reads();
      if ($urandom_range(0, 3) == 0) rs[0] = rd;
      cyc();
    end
    rst = 1'b0; stall = 1'b0; wr = 1'b0;

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the CPU decode/operand-fetch stage. It supersedes the fixed 2-read/1-write, 64-entry register file with configurable width, depth and read-port count. It adds a synchronous reset that clears the array through a hardware sweep sequencer, a ready indication, and an optional write-to-read bypass. Read data are registered: operands for a source address presented in cycle N appear in cycle N+1 and are held while the pipeline stalls.

## Interface
Parameters:
- XLEN, 64: data width in bits.
- NREGS, 32: number of architectural registers; power of two, at least 2.
- NRD, 2: number of read ports, 1 to 4.
- ZERO_REG, 1: when 1, register 0 is hardwired to zero and writes to it are dropped.
- Derived: AW = clog2(NREGS).

Ports:
- clk, input, 1: single clock; all state is updated on its rising edge.
- reset_in, input, 1: reset is synchronous and active-high.
- stall_in, input, 1: when high, read outputs hold their value.
- rs_in, input, NRD*AW: source addresses; port p is bits [p*AW +: AW].
- rd_in, input, AW: destination address.
- rd_write_in, input, 1: write enable.
- rd_value_in, input, XLEN: write data.
- rs_value_out, output, NRD*XLEN: registered read data; port p is bits [p*XLEN +: XLEN].
- ready_out, output, 1: high once the clear sweep has finished and the file is accepting accesses.

## Operation
- The FSM has two states, CLEAR and RUN.
- Reset: reset_in high in any cycle forces state CLEAR, clear counter to 0, all rs_value_out to 0, and ready_out to 0. This applies mid-sweep and mid-run; a reset during a sweep restarts the sweep from 0.
- CLEAR: one register is written per cycle, regs[cnt] <= 0, then cnt increments.
  - When cnt == NREGS-1 has been written, the state goes to RUN.
  - rd_write_in is ignored and rs_value_out is held at 0.
- RUN:
  - Write: if rd_write_in is high and the write is not suppressed, regs[rd_in] <= rd_value_in. A write is suppressed when ZERO_REG=1 and rd_in == 0.
  - Read: if stall_in is low, for each port p, rs_value_out[p] <= value(rs_in[p]). If stall_in is high, rs_value_out holds.
  - Writes are never blocked by stall_in.
- Read value rules:
  - Address 0 with ZERO_REG=1 reads 0.
  - A same-cycle write to the same address is handled as described under Configuration.
  - Several ports may read the same address and each returns an identical value.
- Arithmetic: there is no arithmetic on data. The clear counter is AW+1 bits wide so that it does not wrap before the terminal compare.

## Timing
- Read latency is 1 cycle: an address in cycle N gives data valid after the edge ending cycle N.
- A write issued in cycle N is visible to reads issued in cycle N+1 or later regardless of configuration.
- The clear sweep takes NREGS cycles after reset_in deasserts. ready_out rises on the edge that moves the FSM into RUN, so it is first seen high NREGS cycles after the last reset cycle.
- While stall_in is high the outputs are frozen. On the first unstalled cycle the outputs sample the current rs_in and the current array contents, including any writes made during the stall.
- Under simultaneous reset and write, reset wins and the write is dropped.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: in RUN, if rd_write_in is high, the write is not suppressed, and rs_in[p] == rd_in in the same cycle, port p captures rd_value_in. This gives write-then-read in one cycle.
- Undefined: port p captures the old array contents, so the new value appears only for reads issued from the next cycle onward.
- Both builds must pass the full test plan. The expected values for the same-cycle case differ between the two builds.

## Structure
- The shared package cpu_pkg holds the following:
  - RF_STATE_CLEAR and RF_STATE_RUN state encodings (1 bit).
  - Default XLEN and NREGS constants.
  - The function for the width of the clear counter.
- Sub-module regfile_rdport holds the per-port read mux, zero-register masking, optional bypass compare, and stall-hold output register. It is instantiated NRD times in a generate loop.
- The top level holds the array, the write logic and the clear FSM.

## Test plan
- Reset sweep: hold reset_in for 3 cycles, then release. ready_out must stay 0 for exactly 32 cycles and then go to 1, and every register read must return 0. Assert reset at sweep cycle 10; ready_out must then take a further 32 cycles from the new release.
- Write/read: write 0xDEADBEEF_00000001 to r5 in cycle N and read r5 in cycle N+1. rs_value_out port 0 must equal that value at N+2. Reading r5 on ports 0 and 1 simultaneously must return identical values.
- Zero register: with ZERO_REG=1, write 0xFFFF to r0, then read r0, which must return 0. Repeat with ZERO_REG=0; the read must return 0xFFFF.
- Same-cycle hazard: write 0x1234 to r7 while reading r7 in the same cycle. With REGFILE_BYPASS_EN the read returns 0x1234; without it the read returns the previous value 0.
- Stall hold: read r3 (=0xA) and assert stall_in for 4 cycles while writing 0xB to r3. Outputs must stay 0xA throughout the stall, and the first unstalled read must return 0xB.
- Writes during CLEAR: pulse rd_write_in with r9 = 0x55 during the sweep. After ready_out, r9 must read 0.
